// File: rtl/i2s_rx_tdm.sv
// rtl/i2s_rx_tdm.sv - I2S/TDM serial audio receiver with per-channel capture and short-slot detection.
// Optional per-channel signal detect is enabled by defining I2S_RX_TDM_DETECT_EN.
module i2s_rx_tdm #(
    parameter int DATA_W        = 24,
    parameter int SLOT_W        = 32,
    parameter int NUM_CH        = 2,
    parameter int TDM           = 0,
    parameter int DETECT_THRESH = 1024,
    parameter int DETECT_W      = 4
) (
    input  logic                     i2s_bclk,
    input  logic                     rst,
    input  logic                     i2s_wclk,
    input  logic                     din,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic [NUM_CH-1:0]        ch_detect,
    output logic                     frame_err
);

    localparam int NCH   = (TDM != 0) ? NUM_CH : 2;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(SLOT_W + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

    logic                     r_wclk_lat;
    logic [CNT_W-1:0]         r_bit_cnt;
    logic [CH_W-1:0]          r_ch;
    logic [DATA_W-2:0]        r_shift;
    logic [NUM_CH*DATA_W-1:0] r_data_out;
    logic                     r_data_valid;
    logic                     r_frame_err;

    logic                     w_edge;
    logic                     w_start;
    logic                     w_capture;
    logic                     w_commit;
    logic [DATA_W-1:0]        w_sample;

    assign w_edge    = (i2s_wclk != r_wclk_lat);
    // TDM frames start only on a rising word clock; I2S starts a slot on either edge
    assign w_start   = (TDM != 0) ? (w_edge && i2s_wclk) : w_edge;
    assign w_capture = !w_start && (r_bit_cnt <= DATA_LAST);
    assign w_commit  = w_capture && (r_bit_cnt == DATA_LAST);
    assign w_sample  = {r_shift, din};

    always_ff @(posedge i2s_bclk) begin
        if (rst) begin
            r_wclk_lat   <= 1'b0;
            r_bit_cnt    <= CNT_MAX;
            r_ch         <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wclk_lat   <= i2s_wclk;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_start) begin
                r_frame_err <= (r_bit_cnt <= DATA_LAST);
                r_bit_cnt   <= '0;
                r_ch        <= (TDM != 0) ? '0 : CH_W'(i2s_wclk);
            end else if (r_bit_cnt != CNT_MAX) begin
                if (w_capture) begin
                    r_shift <= w_sample[DATA_W-2:0];
                end
                if (w_commit) begin
                    r_data_out[r_ch*DATA_W +: DATA_W] <= w_sample;
                    r_data_valid <= (r_ch == CH_LAST);
                end
                if ((TDM != 0) && (r_bit_cnt == SLOT_LAST)) begin
                    if (r_ch == CH_LAST) begin
                        r_bit_cnt <= CNT_MAX;
                    end else begin
                        r_ch      <= r_ch + 1'b1;
                        r_bit_cnt <= '0;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;

`ifdef I2S_RX_TDM_DETECT_EN
    localparam logic signed [32:0] THR_P = 33'(DETECT_THRESH);
    localparam logic signed [32:0] THR_N = -THR_P;

    logic signed [32:0]  w_sample_ext;
    logic                w_active;
    logic [DETECT_W-1:0] r_quiet [NUM_CH];
    logic [NUM_CH-1:0]   r_ch_detect;

    assign w_sample_ext = {{(33-DATA_W){w_sample[DATA_W-1]}}, w_sample};
    assign w_active     = (w_sample_ext >= THR_P) || (w_sample_ext <= THR_N);

    // Quiet counter holds at its maximum so detect stays low until an active sample
    always_ff @(posedge i2s_bclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_quiet[i] <= '0;
            end
            r_ch_detect <= '1;
        end else if (w_commit) begin
            if (w_active) begin
                r_quiet[r_ch]     <= '0;
                r_ch_detect[r_ch] <= 1'b1;
            end else if (r_quiet[r_ch] == '1) begin
                r_ch_detect[r_ch] <= 1'b0;
            end else begin
                r_quiet[r_ch] <= r_quiet[r_ch] + 1'b1;
            end
        end
    end

    assign ch_detect = r_ch_detect;
`else
    assign ch_detect = '1;
`endif

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// tb/tb_i2s_rx_tdm.sv - scoreboard bench for i2s_rx_tdm in I2S and 4-channel TDM framing.
module tb_i2s_rx_tdm;

`ifdef I2S_RX_TDM_DETECT_EN
    localparam bit DET_EN = 1'b1;
`else
    localparam bit DET_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0  = 1'b1;
    logic        wclk0 = 1'b0;
    logic        din0  = 1'b0;
    logic [47:0] dout0;
    logic        dv0;
    logic        fe0;
    logic [1:0]  det0;

    logic        rst1  = 1'b1;
    logic        wclk1 = 1'b0;
    logic        din1  = 1'b0;
    logic [95:0] dout1;
    logic        dv1;
    logic        fe1;
    logic [3:0]  det1;

    i2s_rx_tdm u_i2s (
        .i2s_bclk   (clk),
        .rst        (rst0),
        .i2s_wclk   (wclk0),
        .din        (din0),
        .data_out   (dout0),
        .data_valid (dv0),
        .ch_detect  (det0),
        .frame_err  (fe0)
    );

    i2s_rx_tdm #(
        .DATA_W (24),
        .SLOT_W (32),
        .NUM_CH (4),
        .TDM    (1)
    ) u_tdm (
        .i2s_bclk   (clk),
        .rst        (rst1),
        .i2s_wclk   (wclk1),
        .din        (din1),
        .data_out   (dout1),
        .data_valid (dv1),
        .ch_detect  (det1),
        .frame_err  (fe1)
    );

    typedef struct {
        logic [47:0] data;
        logic [1:0]  det;
    } exp0_t;

    int          checks = 0;
    int          errors = 0;
    exp0_t       exp0_q [$];
    logic [47:0] err0_q [$];
    logic [95:0] exp1_q [$];
    exp0_t       e0;
    logic [47:0] ee0;
    logic [95:0] e1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // slot of len bclks: wclk edge with the previous LSB, then 24 data bits MSB first, ones as padding
    task automatic i2s_slot(input logic w, input logic [23:0] v, input int len);
        for (int j = 0; j < len; j++) begin
            wclk0 = w;
            din0  = (j >= 1 && j <= 24) ? v[24-j] : 1'b1;
            tick();
        end
    endtask

    task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r, input logic [1:0] det);
        exp0_q.push_back('{data: {r, l}, det: (DET_EN ? det : 2'b11)});
        i2s_slot(1'b0, l, 32);
        i2s_slot(1'b1, r, 32);
    endtask

    task automatic tdm_frame(input logic [23:0] s0, input logic [23:0] s1,
                             input logic [23:0] s2, input logic [23:0] s3);
        logic [23:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        exp1_q.push_back({s3, s2, s1, s0});
        for (int j = 0; j < 137; j++) begin
            wclk1 = (j < 64);
            if (j >= 1 && j <= 128) begin
                din1 = (((j-1) % 32) < 24) ? s[(j-1)/32][23-((j-1)%32)] : 1'b1;
            end else begin
                din1 = 1'b1;
            end
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (dv0) begin
            chk("i2s_valid_expected", 96'(exp0_q.size() > 0), 96'd1);
            if (exp0_q.size() > 0) begin
                e0 = exp0_q.pop_front();
                chk("i2s_data", 96'(dout0), 96'(e0.data));
                chk("i2s_detect", 96'(det0), 96'(e0.det));
            end
        end
        if (fe0) begin
            chk("i2s_err_expected", 96'(err0_q.size() > 0), 96'd1);
            if (err0_q.size() > 0) begin
                ee0 = err0_q.pop_front();
                chk("i2s_err_data_kept", 96'(dout0), 96'(ee0));
            end
        end
        if (dv1) begin
            chk("tdm_valid_expected", 96'(exp1_q.size() > 0), 96'd1);
            if (exp1_q.size() > 0) begin
                e1 = exp1_q.pop_front();
                chk("tdm_data", dout1, e1);
            end
        end
        if (fe1) begin
            checks++;
            errors++;
            $display("FAIL tdm_frame_err: got 1 expected 0");
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_data_out", 96'(dout0), 96'd0);
        chk("rst_data_valid", 96'(dv0), 96'd0);
        chk("rst_frame_err", 96'(fe0), 96'd0);
        chk("rst_ch_detect", 96'(det0), 96'd3);
        rst0 = 1'b0;

        // sync slot: first edge after reset is the rising wclk into the right slot
        exp0_q.push_back('{data: {24'hABCDEF, 24'h000000}, det: 2'b11});
        i2s_slot(1'b1, 24'hABCDEF, 32);
        i2s_frame(24'h123456, 24'hFEDCBA, 2'b11);
        i2s_frame(24'h111111, 24'h222222, 2'b11);

        // right slot cut to 16 bits
        i2s_slot(1'b0, 24'h333333, 32);
        err0_q.push_back({24'h222222, 24'h333333});
        i2s_slot(1'b1, 24'h999999, 17);
        i2s_frame(24'h444444, 24'h555555, 2'b11);

        // reset in the middle of a left slot
        i2s_slot(1'b0, 24'h666666, 10);
        rst0 = 1'b1;
        tick();
        chk("midrst_data_out", 96'(dout0), 96'd0);
        chk("midrst_data_valid", 96'(dv0), 96'd0);
        chk("midrst_frame_err", 96'(fe0), 96'd0);
        chk("midrst_ch_detect", 96'(det0), 96'd3);
        rst0 = 1'b0;
        for (int j = 0; j < 20; j++) begin
            din0 = j[0];
            tick();
        end
        chk("midrst_no_capture", 96'(dout0), 96'd0);
        exp0_q.push_back('{data: {24'h0A0A0A, 24'h000000}, det: 2'b11});
        i2s_slot(1'b1, 24'h0A0A0A, 32);
        i2s_frame(24'h765432, 24'h13579B, 2'b11);

        // signal detect: 16 quiet samples, threshold boundaries
        for (int n = 1; n <= 16; n++) begin
            i2s_frame(24'h000000, 24'h000000, (n == 16) ? 2'b00 : 2'b11);
        end
        i2s_frame(24'hFFFC00, 24'h000000, 2'b01);
        for (int n = 1; n <= 16; n++) begin
            i2s_frame(24'h0003FF, 24'h000400, (n == 16) ? 2'b10 : 2'b11);
        end
        i2s_frame(24'h000400, 24'hFFFC01, 2'b11);

        // TDM instance
        chk("tdm_rst_data_out", dout1, 96'd0);
        chk("tdm_rst_data_valid", 96'(dv1), 96'd0);
        chk("tdm_rst_ch_detect", 96'(det1), 96'hF);
        rst1 = 1'b0;
        tick();
        tdm_frame(24'h000001, 24'h000002, 24'h000003, 24'h000004);
        tdm_frame(24'h800000, 24'h7FFFFF, 24'hA5A5A5, 24'h0F0F0F);
        tdm_frame(24'h000001, 24'h000002, 24'h000003, 24'h000004);
        wclk1 = 1'b0;
        repeat (8) tick();

        chk("i2s_valid_all_seen", 96'(exp0_q.size()), 96'd0);
        chk("i2s_err_all_seen", 96'(err0_q.size()), 96'd0);
        chk("tdm_valid_all_seen", 96'(exp1_q.size()), 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
